seq_det_moore_fsm: RTL and testbench

SEQ_DET_MOORE_FSM -- requirements
Module: seq_det_moore_fsm

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_det_moore_fsm.sv | 56 +++++
 tb/tb_seq_det_moore_fsm.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding for the 1011 sequence detector
//
// Purpose : state enumeration (3-bit encoding) and pattern constants used by
//           seq_det_moore_fsm.
// Ports   : none (package).
package seq_det_pkg;

  // Each state names the longest prefix of 1011 seen so far.
  typedef enum logic [2:0] {
    ZERO         = 3'd0,
    ONE          = 3'd1,
    ONE_ZERO     = 3'd2,
    ONE_ZERO_ONE = 3'd3,
    DETECT       = 3'd4
  } state_t;

  localparam int         PATTERN_LEN = 4;
  localparam logic [3:0] PATTERN     = 4'b1011;

endpackage

// File: rtl/seq_det_moore_fsm.sv
// rtl/seq_det_moore_fsm.sv - Moore FSM detecting the serial pattern 1011
//
// Purpose : watches a serial bit stream and flags each occurrence of 1011
//           (first-received bit first) with a one-cycle pulse.
// Config  : SEQ_DET_OVERLAP_EN defined   -> overlapping detection
//           SEQ_DET_OVERLAP_EN undefined -> non-overlapping detection
// Ports   : clock        in  1  rising-edge clock
//           reset        in  1  synchronous active-high reset
//           sequence_in  in  1  serial data bit, sampled every rising edge
//           detector_out out 1  high while the FSM sits in DETECT
module seq_det_moore_fsm
  import seq_det_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic sequence_in,
  output logic detector_out
);

  state_t state;
  state_t next_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ZERO;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = ZERO;
    case (state)
      ZERO:         next_state = sequence_in ? ONE          : ZERO;
      ONE:          next_state = sequence_in ? ONE          : ONE_ZERO;
      ONE_ZERO:     next_state = sequence_in ? ONE_ZERO_ONE : ZERO;
      // A 0 after 101 still leaves "10" as a live prefix.
      ONE_ZERO_ONE: next_state = sequence_in ? DETECT       : ONE_ZERO;
`ifdef SEQ_DET_OVERLAP_EN
      // The trailing 1 of the match seeds the next one.
      DETECT:       next_state = sequence_in ? ONE          : ONE_ZERO;
`else
      // Matched bits are consumed; only the new bit counts.
      DETECT:       next_state = sequence_in ? ONE          : ZERO;
`endif
      // Unused encodings recover to ZERO.
      default:      next_state = ZERO;
    endcase
  end

  // Decoded from the registered state only, so no path from sequence_in.
  always_comb begin
    detector_out = (state == DETECT);
  end

endmodule

// File: tb/tb_seq_det_moore_fsm.sv
// tb/tb_seq_det_moore_fsm.sv - self-checking bench for seq_det_moore_fsm
module tb_seq_det_moore_fsm;

  logic clock;
  logic reset;
  logic sequence_in;
  logic detector_out;

  int n_cmp;
  int n_fail;

  // Bits received since the last reset (or last consumed match).
  bit hist[$];

  seq_det_moore_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .detector_out (detector_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected detector_out after the edge that samples (b, r).
  function automatic logic model_step(input logic b, input logic r);
    if (r) begin
      hist.delete();
      return 1'b0;
    end
    hist.push_back(b);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() == 4 && hist[0] == 1'b1 && hist[1] == 1'b0 &&
        hist[2] == 1'b1 && hist[3] == 1'b1) begin
`ifndef SEQ_DET_OVERLAP_EN
      hist.delete();
`endif
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Apply one bit, let one edge pass, sample 1 time unit later.
  task automatic drive(input logic b, input logic r, output logic obs);
    sequence_in = b;
    reset       = r;
    @(posedge clock);
    #1;
    obs = detector_out;
  endtask

  task automatic clean_reset();
    logic obs;
    logic exp;
    drive(1'b0, 1'b1, obs);
    exp = model_step(1'b0, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL clean_reset: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_reset();
    logic obs;
    logic exp;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, obs);
      exp = model_step(1'b0, 1'b1);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, exp);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, obs);
      exp = model_step(1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic run_seq(input string name, input logic [15:0] bits, input int len,
                         input int want_pulses);
    logic obs;
    logic exp;
    int   pulses;
    pulses = 0;
    for (int i = len - 1; i >= 0; i--) begin
      drive(bits[i], 1'b0, obs);
      exp = model_step(bits[i], 1'b0);
      if (obs === 1'b1) pulses++;
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s bit%0d: got %b want %b", name, len - 1 - i, obs, exp);
      end
    end
    // One trailing 0 to show the pulse drops again.
    drive(1'b0, 1'b0, obs);
    exp = model_step(1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s tail: got %b want %b", name, obs, exp);
    end
    n_cmp++;
    if (pulses != want_pulses) begin
      n_fail++;
      $display("FAIL %s pulses: got %0d want %0d", name, pulses, want_pulses);
    end
  endtask

  task automatic test_no_match();
    clean_reset();
    run_seq("no_match", 16'b0000_0011_0011_1100, 12, 0);
  endtask

  task automatic test_single_match();
    clean_reset();
    run_seq("single_match", 16'b1011, 4, 1);
  endtask

  task automatic test_overlap();
    logic obs;
    logic exp;
    logic [6:0] bits;
    int first;
    int second;
    int want;
`ifdef SEQ_DET_OVERLAP_EN
    want = 2;
`else
    want = 1;
`endif
    bits   = 7'b1011011;
    first  = -1;
    second = -1;
    clean_reset();
    for (int i = 6; i >= 0; i--) begin
      drive(bits[i], 1'b0, obs);
      exp = model_step(bits[i], 1'b0);
      if (obs === 1'b1) begin
        if (first < 0) first = 6 - i;
        else second = 6 - i;
      end
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL overlap bit%0d: got %b want %b", 6 - i, obs, exp);
      end
    end
    n_cmp++;
    if (((first >= 0) ? 1 : 0) + ((second >= 0) ? 1 : 0) != want) begin
      n_fail++;
      $display("FAIL overlap pulses: first %0d second %0d want %0d pulses", first, second, want);
    end
    if (want == 2) begin
      n_cmp++;
      if (second - first != 3) begin
        n_fail++;
        $display("FAIL overlap spacing: got %0d want 3", second - first);
      end
    end
  endtask

  task automatic test_reset_mid_pattern();
    logic obs;
    logic exp;
    clean_reset();
    run_seq("pre_reset", 16'b101, 3, 0);
    drive(1'b1, 1'b1, obs);
    exp = model_step(1'b1, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mid_reset: got %b want %b", obs, exp);
    end
    run_seq("post_reset_1", 16'b1, 1, 0);
    run_seq("post_reset_011", 16'b011, 3, 0);
    clean_reset();
    run_seq("post_reset_fresh", 16'b1011, 4, 1);
  endtask

  task automatic test_reset_hold();
    logic obs;
    logic exp;
    clean_reset();
    for (int i = 3; i >= 0; i--) begin
      drive(4'b1011 >> i, 1'b0, obs);
      exp = model_step(4'b1011 >> i, 1'b0);
    end
    n_cmp++;
    if (obs !== 1'b1 || exp !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_detect: got %b want 1 (model %b)", obs, exp);
    end
    reset = 1'b1;
    #2;
    n_cmp++;
    if (detector_out !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_before_edge: got %b want 1", detector_out);
    end
    @(posedge clock);
    #1;
    exp = model_step(1'b0, 1'b1);
    n_cmp++;
    if (detector_out !== exp) begin
      n_fail++;
      $display("FAIL hold_after_edge: got %b want %b", detector_out, exp);
    end
  endtask

  task automatic test_fallback();
    clean_reset();
    run_seq("fallback", 16'b101011, 6, 1);
  endtask

  task automatic test_random();
    logic obs;
    logic exp;
    logic prev;
    logic b;
    logic r;
    prev = 1'b0;
    clean_reset();
    for (int i = 0; i < 3000; i++) begin
      b = logic'($urandom_range(0, 1));
      r = ($urandom_range(0, 63) == 0);
      drive(b, r, obs);
      exp = model_step(b, r);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] in=%b rst=%b: got %b want %b", i, b, r, obs, exp);
      end
      n_cmp++;
      if (prev === 1'b1 && obs === 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got 1 twice want single pulse", i);
      end
      prev = obs;
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    sequence_in = 1'b0;
    #1;
    test_reset();
    test_no_match();
    test_single_match();
    test_overlap();
    test_reset_mid_pattern();
    test_reset_hold();
    test_fallback();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
